mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory stage that sits directly downstream of the execute stage and consumes its outputs: wbEn, memREn, memWEn, aluRes, exeValRm and exeDest.
- Performs data-memory loads and stores over a request/acknowledge handshake to an external data memory that may take several cycles.
- Raises a freeze signal that stalls all upstream stages until the access completes.
- Registers the results into the MEM/WB pipeline register that feeds write-back.

Parameters:
- ADDR_BASE, 1024: byte offset subtracted from aluRes before addressing memory.
- ADDR_W, 16: word-address width presented to the memory.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- wbEnIn  in  1  write-back enable from execute.
- memREnIn  in  1  load request from execute.
- memWEnIn  in  1  store request from execute.
- aluRes  in  32  byte address for load/store, or ALU result to forward.
- exeValRm  in  32  store data.
- exeDest  in  4  destination register number.
- memReq  out  1  memory request, registered.
- memWe  out  1  1 = write, 0 = read; valid while memReq=1.
- memAddr  out  ADDR_W  word address.
- memWData  out  32  store data.
- memRData  in  32  read data; valid in the cycle memAck=1.
- memAck  in  1  one-cycle completion pulse.
- freeze  out  1  stall request to PC, IF, ID and EX pipeline registers.
- wbEnOut  out  1  MEM/WB write-back enable.
- memREnOut  out  1  MEM/WB load flag (write-back mux select).
- aluResOut  out  32  MEM/WB ALU result.
- memDataOut  out  32  MEM/WB load data.
- destOut  out  4  MEM/WB destination register.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - state=IDLE; memReq=0; all MEM/WB outputs=0.
  - memWe, memAddr and memWData are 0 from the capture registers.
- Address:
  - memAddr = (aluRes - ADDR_BASE)[ADDR_W+1:2].
  - The low 2 bits are ignored, so misaligned addresses truncate.
  - Addresses below ADDR_BASE or beyond range wrap modulo 2^ADDR_W words; no error is raised.
- memAccess = memREnIn | memWEnIn. If both are set (illegal), treat the access as a write.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE:
    - If memAccess: capture address, write data and memWe into registers, go to ACCESS, freeze=1 (combinational).
    - Otherwise: freeze=0.
  - ACCESS:
    - memReq=1 and freeze=1.
    - Address, data and memWe are held stable until ack.
    - On memAck=1: capture memRData into the load-data register, go to DONE.
  - DONE:
    - memReq=0, freeze=0.
    - Always return to IDLE; the still-present EX inputs of the same instruction must not retrigger an access.
- freeze = (IDLE & memAccess) | ACCESS.
- Minimum freeze is 2 cycles (an ack in the first ACCESS cycle). There is no timeout: the stage waits on ack indefinitely.
- MEM/WB register loads on a rising edge whenever freeze=0:
  - wbEnOut ← wbEnIn
  - memREnOut ← memREnIn
  - aluResOut ← aluRes
  - destOut ← exeDest
  - memDataOut ← the captured load data (the DONE cycle supplies it).
- Non-memory instruction latency: 1 cycle, no stall.
- MEM/WB register behaviour while frozen:
  - It holds its previous value; it is not bubbled.
  - Write-back of the older instruction therefore repeats, which is harmless because it is idempotent.
- Store: wbEnOut follows wbEnIn (0 for a store); memDataOut is don't-care but deterministic (holds its last value).
- memAck in IDLE or DONE is ignored.
- Reset mid-ACCESS: memReq drops immediately, the FSM returns to IDLE and no MEM/WB update occurs.
- Back-to-back loads: each takes IDLE→ACCESS→DONE, with one DONE cycle between requests.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2);
  - ADDR_BASE default;
  - data-width constant 32;
  - register-number width 4.
- One sub-module, pipe_reg_mem_wb: posedge register with async active-low reset and a load enable (= ~freeze), carrying wbEn, memREn, aluRes, memData and dest.

Test Plan:
- ALU op: aluRes=0x55, wbEnIn=1, exeDest=3, no mem enables → freeze stays 0, memReq never asserted; next edge aluResOut=0x55, destOut=3, wbEnOut=1.
- Load: aluRes=1028, memREnIn=1, wbEnIn=1, exeDest=5; memory acks 3 cycles after memReq with memRData=0xDEADBEEF.
  - Expect memAddr=1, memWe=0, freeze high for 4 cycles.
  - After DONE: memDataOut=0xDEADBEEF, memREnOut=1, destOut=5.
- Store: aluRes=1032, exeValRm=0x12345678, memWEnIn=1, ack on the first ACCESS cycle → memWe=1, memAddr=2, memWData=0x12345678, freeze exactly 2 cycles, wbEnOut=0.
- Boundary: aluRes=1023 → memAddr=0xFFFF (wrap); aluRes=1030 → memAddr=1 (misaligned truncation); memREnIn=memWEnIn=1 → memWe=1.
- Reset (rst=0) asserted mid-ACCESS with no ack → memReq and freeze go 0 immediately, outputs 0; after release, a new load completes normally.
- Stray memAck pulse in IDLE, then a load with normal ack → stray pulse ignored (no state change), load data correct.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the memory stage controller and its MEM/WB register.
package mem_stage_ctrl_pkg;

    localparam int unsigned AddrBaseDefault = 1024;
    localparam int unsigned DataW           = 32;
    localparam int unsigned RegW            = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    // Byte offset of an execute-stage address into the data memory window.
    function automatic logic [DataW-1:0] mem_offset(input logic [DataW-1:0] addr,
                                                    input logic [DataW-1:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_pipe_reg_mem_wb.sv
// MEM/WB pipeline register: loads on load_i, holds otherwise, async active-low reset.
module pipe_reg_mem_wb
    import mem_stage_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             wb_en_i,
    input  logic             mem_ren_i,
    input  logic [DataW-1:0] alu_res_i,
    input  logic [DataW-1:0] mem_data_i,
    input  logic [RegW-1:0]  dest_i,
    output logic             wb_en_o,
    output logic             mem_ren_o,
    output logic [DataW-1:0] alu_res_o,
    output logic [DataW-1:0] mem_data_o,
    output logic [RegW-1:0]  dest_o
);

    logic             wb_en_q;
    logic             mem_ren_q;
    logic [DataW-1:0] alu_res_q;
    logic [DataW-1:0] mem_data_q;
    logic [RegW-1:0]  dest_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_en_q    <= 1'b0;
            mem_ren_q  <= 1'b0;
            alu_res_q  <= '0;
            mem_data_q <= '0;
            dest_q     <= '0;
        end else if (load_i) begin
            wb_en_q    <= wb_en_i;
            mem_ren_q  <= mem_ren_i;
            alu_res_q  <= alu_res_i;
            mem_data_q <= mem_data_i;
            dest_q     <= dest_i;
        end
    end

    assign wb_en_o    = wb_en_q;
    assign mem_ren_o  = mem_ren_q;
    assign alu_res_o  = alu_res_q;
    assign mem_data_o = mem_data_q;
    assign dest_o     = dest_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: drives a req/ack data-memory access, freezes upstream while it is
// outstanding, and feeds the MEM/WB register.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_BASE = AddrBaseDefault,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wbEnIn,
    input  logic              memREnIn,
    input  logic              memWEnIn,
    input  logic [DataW-1:0]  aluRes,
    input  logic [DataW-1:0]  exeValRm,
    input  logic [RegW-1:0]   exeDest,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DataW-1:0]  memWData,
    input  logic [DataW-1:0]  memRData,
    input  logic              memAck,
    output logic              freeze,
    output logic              wbEnOut,
    output logic              memREnOut,
    output logic [DataW-1:0]  aluResOut,
    output logic [DataW-1:0]  memDataOut,
    output logic [RegW-1:0]   destOut
);

    state_e            state_q, state_d;
    logic              req_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DataW-1:0]  wdata_q, wdata_d;
    logic [DataW-1:0]  rdata_q, rdata_d;
    logic              freeze_c;
    logic              mem_access;
    logic [DataW-1:0]  offset;

    assign mem_access = memREnIn | memWEnIn;
    assign offset     = mem_offset(aluRes, DataW'(ADDR_BASE));

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        freeze_c = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_access) begin
                    freeze_c = 1'b1;
                    // A simultaneous read and write request is treated as a write.
                    we_d     = memWEnIn;
                    addr_d   = offset[ADDR_W+1:2];
                    wdata_d  = exeValRm;
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                freeze_c = 1'b1;
                if (memAck) begin
                    if (!we_q) begin
                        rdata_d = memRData;
                    end
                    state_d = StDone;
                end
            end
            // EX still presents the same instruction here; never re-enter an access.
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == StAccess);
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // No access can start while reset is held, so no stall is requested either.
    assign freeze   = freeze_c & rst;
    assign memReq   = req_q;
    assign memWe    = we_q;
    assign memAddr  = addr_q;
    assign memWData = wdata_q;

    pipe_reg_mem_wb u_pipe_reg_mem_wb (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (~freeze),
        .wb_en_i    (wbEnIn),
        .mem_ren_i  (memREnIn),
        .alu_res_i  (aluRes),
        .mem_data_i (rdata_q),
        .dest_i     (exeDest),
        .wb_en_o    (wbEnOut),
        .mem_ren_o  (memREnOut),
        .alu_res_o  (aluResOut),
        .mem_data_o (memDataOut),
        .dest_o     (destOut)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases plus randomized instruction stream.
module tb_mem_stage_ctrl;

    localparam int unsigned Base = 1024;
    localparam int unsigned AW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wbEnIn = 1'b0, memREnIn = 1'b0, memWEnIn = 1'b0;
    logic [31:0]   aluRes = '0, exeValRm = '0, memRData = '0;
    logic [3:0]    exeDest = '0;
    logic          memAck = 1'b0;
    logic          memReq, memWe, freeze, wbEnOut, memREnOut;
    logic [AW-1:0] memAddr;
    logic [31:0]   memWData, aluResOut, memDataOut;
    logic [3:0]    destOut;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_rdata = '0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.ADDR_BASE(Base), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wbEnIn     (wbEnIn),
        .memREnIn   (memREnIn),
        .memWEnIn   (memWEnIn),
        .aluRes     (aluRes),
        .exeValRm   (exeValRm),
        .exeDest    (exeDest),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memWData   (memWData),
        .memRData   (memRData),
        .memAck     (memAck),
        .freeze     (freeze),
        .wbEnOut    (wbEnOut),
        .memREnOut  (memREnOut),
        .aluResOut  (aluResOut),
        .memDataOut (memDataOut),
        .destOut    (destOut)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Word address of a byte address inside the memory window, wrapping on 2^AW words.
    function automatic logic [31:0] exp_addr(input logic [31:0] a);
        logic [31:0] off;
        off = a - Base;
        return (off / 4) % (32'd1 << AW);
    endfunction

    task automatic clear_inputs();
        wbEnIn = 1'b0; memREnIn = 1'b0; memWEnIn = 1'b0;
        aluRes = '0; exeValRm = '0; exeDest = '0; memAck = 1'b0;
    endtask

    task automatic check_mem_wb_zero(input string tag);
        check_eq({tag, "_wb"}, wbEnOut, 0);
        check_eq({tag, "_ren"}, memREnOut, 0);
        check_eq({tag, "_alu"}, aluResOut, 0);
        check_eq({tag, "_data"}, memDataOut, 0);
        check_eq({tag, "_dest"}, destOut, 0);
    endtask

    // One instruction through the stage; ack_delay = ACCESS cycles without ack before the ack.
    task automatic run_instr(input logic wb, input logic ren, input logic wen,
                             input logic [31:0] alu, input logic [31:0] val,
                             input logic [3:0] dest, input int ack_delay,
                             input logic [31:0] rd);
        int frz = 0;
        int acc = 0;
        int cyc = 0;
        bit mem;
        mem = ren | wen;
        @(negedge clk);
        wbEnIn = wb; memREnIn = ren; memWEnIn = wen;
        aluRes = alu; exeValRm = val; exeDest = dest;
        memAck = 1'b0; memRData = rd;
        #1;
        while (freeze === 1'b1 && cyc < 64) begin
            frz++;
            if (memReq === 1'b1) begin
                acc++;
                if (acc == 1) begin
                    check_eq("mem_addr", 32'(memAddr), exp_addr(alu));
                    check_eq("mem_we", memWe, wen);
                    if (wen) check_eq("mem_wdata", memWData, val);
                end
                if (acc == ack_delay + 1) memAck = 1'b1;
            end
            @(negedge clk);
            memAck = 1'b0;
            #1;
            cyc++;
        end
        if (cyc >= 64) check_eq("freeze_timeout", freeze, 0);
        check_eq("freeze_cycles", frz, mem ? ack_delay + 2 : 0);
        check_eq("req_low_after", memReq, 0);
        if (mem && !wen) last_rdata = rd;
        @(posedge clk);
        #1;
        check_eq("wb_en_out", wbEnOut, wb);
        check_eq("mem_ren_out", memREnOut, ren);
        check_eq("alu_res_out", aluResOut, alu);
        check_eq("dest_out", destOut, dest);
        check_eq("mem_data_out", memDataOut, last_rdata);
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        #1;
        check_eq("rst_req", memReq, 0);
        check_eq("rst_freeze", freeze, 0);
        check_eq("rst_addr", 32'(memAddr), 0);
        check_eq("rst_we", memWe, 0);
        check_eq("rst_wdata", memWData, 0);
        check_mem_wb_zero("rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // ALU op, load with late ack, store with immediate ack
        run_instr(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3, 0, 32'hA5A5A5A5);
        run_instr(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd5, 2, 32'hDEADBEEF);
        run_instr(1'b0, 1'b0, 1'b1, 32'd1032, 32'h12345678, 4'd7, 0, 32'h0BADF00D);
        // Address wrap, misaligned truncation, read+write collision
        run_instr(1'b1, 1'b1, 1'b0, 32'd1023, 32'h0, 4'd1, 1, 32'hCAFEF00D);
        run_instr(1'b1, 1'b1, 1'b0, 32'd1030, 32'h0, 4'd2, 0, 32'h13579BDF);
        run_instr(1'b0, 1'b1, 1'b1, 32'd1100, 32'hFEEDFACE, 4'd9, 1, 32'h2468ACE0);

        // Reset asserted while an access is outstanding
        @(negedge clk);
        wbEnIn = 1'b1; memREnIn = 1'b1; aluRes = 32'd1040; exeDest = 4'd6;
        repeat (2) @(negedge clk);
        #1;
        check_eq("pre_rst_req", memReq, 1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_req", memReq, 0);
        check_eq("mid_rst_freeze", freeze, 0);
        check_eq("mid_rst_addr", 32'(memAddr), 0);
        check_mem_wb_zero("mid_rst");
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        last_rdata = '0;
        run_instr(1'b1, 1'b1, 1'b0, 32'd1044, 32'h0, 4'd4, 1, 32'h11223344);

        // Stray ack while idle
        @(negedge clk);
        memAck = 1'b1;
        memRData = 32'hBAADBAAD;
        #1;
        check_eq("stray_freeze", freeze, 0);
        @(negedge clk);
        memAck = 1'b0;
        #1;
        check_eq("stray_req", memReq, 0);
        check_eq("stray_freeze2", freeze, 0);
        check_eq("stray_data", memDataOut, last_rdata);
        run_instr(1'b1, 1'b1, 1'b0, 32'd1200, 32'h0, 4'd8, 0, 32'h55AA55AA);

        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a = ($urandom_range(0, 1) == 1) ? Base + $urandom_range(0, 4095) : $urandom;
            run_instr(1'($urandom), kind == 1 || kind == 3, kind == 2 || kind == 3,
                      a, $urandom, 4'($urandom), $urandom_range(0, 4), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
